// File: rtl/im_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
package im_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned CNT_W = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/im_loader_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the cycle after the 4th byte.
module im_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_lane_c,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] lane;

  assign last_lane_c = (lane == 2'd3);

  // Shifting right puts the first byte of a word in [7:0] once four bytes are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && last_lane_c;
      if (clear) begin
        lane <= 2'd0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        word <= {byte_in, word[31:8]};
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot loader: receives a framed byte image, writes it to IM word by word and releases the CPU on a good checksum.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t           state;
  logic [7:0]       cnt_hi;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] wcnt;
  logic [7:0]       csum;

  logic             xfer_c;
  logic             data_byte_c;
  logic             last_lane_c;
  logic             clear_c;
  logic [CNT_W-1:0] n_c;

  assign xfer_c      = in_valid && in_ready;
  assign data_byte_c = xfer_c && (state == S_DATA);
  assign clear_c     = reload && ((state == S_DONE) || (state == S_ERR));
  assign n_c         = CNT_W'({cnt_hi, in_data});

  im_loader_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_c),
    .byte_valid  (data_byte_c),
    .byte_in     (in_data),
    .last_lane_c (last_lane_c),
    .word_valid  (im_we),
    .word        (im_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cnt_hi    <= 8'd0;
      n_words   <= '0;
      wcnt      <= '0;
      csum      <= 8'd0;
      im_addr   <= '0;
    end else begin
      // The last word leaves im_addr at N-1, so it never wraps even for N == DEPTH.
      if (im_we && (state == S_DATA)) im_addr <= im_addr + ADDR_W'(1);

      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (xfer_c && (in_data == SYNC_BYTE)) state <= S_CNT_HI;
        end
        S_CNT_HI: begin
          if (xfer_c) begin
            cnt_hi <= in_data;
            state  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer_c) begin
            n_words <= n_c;
            if (n_c > CNT_W'(DEPTH)) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (n_c == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            csum <= csum ^ in_data;
            if (last_lane_c) begin
              wcnt <= wcnt + CNT_W'(1);
              if (wcnt + CNT_W'(1) == n_words) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer_c) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt_hi    <= 8'd0;
            n_words   <= '0;
            wcnt      <= '0;
            csum      <= 8'd0;
            im_addr   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: framing, checksum, errors, mid-frame reset and reload.
module tb_im_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reload    (reload),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Record every IM write as seen mid-cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1 (byte %h)", in_ready, b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, in_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: we=%b addr=%0d wdata=%h hold=%b done=%b err=%b rdy=%b required 0 0 0 1 0 0 0",
               im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, in_ready);
    end
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
    @(negedge clk);
    n_cmp++;
    if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL good_hold_before_csum: cpu_hold=%b required 1", cpu_hold); end
    send_byte(8'h2A, 0);
    @(negedge clk);
    n_cmp++;
    if ({load_done, load_err, cpu_hold, in_ready} !== 4'b1000) begin
      n_bad++; $display("FAIL good_status: done=%b err=%b hold=%b rdy=%b required 1 0 0 0",
                        load_done, load_err, cpu_hold, in_ready);
    end
    n_cmp++;
    if (wr_addr.size() !== 2) begin
      n_bad++; $display("FAIL good_write_count: %0d required 2", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678) begin
        n_bad++; $display("FAIL good_word0: addr=%0d data=%h required 0 12345678", wr_addr[0], wr_data[0]);
      end
      n_cmp++;
      if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'hDEADBEEF) begin
        n_bad++; $display("FAIL good_word1: addr=%0d data=%h required 1 deadbeef", wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_bad_csum();
    pulse_reload();
    @(negedge clk);
    n_cmp++;
    if ({load_done, load_err, cpu_hold, in_ready} !== 4'b0011) begin
      n_bad++; $display("FAIL reload_status: done=%b err=%b hold=%b rdy=%b required 0 0 1 1",
                        load_done, load_err, cpu_hold, in_ready);
    end
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B}, 2);
    @(negedge clk);
    n_cmp++;
    if ({load_done, load_err, cpu_hold, in_ready} !== 4'b0110) begin
      n_bad++; $display("FAIL badcs_status: done=%b err=%b hold=%b rdy=%b required 0 1 1 0",
                        load_done, load_err, cpu_hold, in_ready);
    end
    n_cmp++;
    if (wr_addr.size() !== 2 || wr_data[1] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL badcs_writes: count=%0d required 2 with word1 deadbeef", wr_addr.size());
    end
  endtask

  task automatic test_junk_empty();
    pulse_reload();
    clear_log();
    send_frame('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00}, 1);
    @(negedge clk);
    n_cmp++;
    if ({load_done, load_err, cpu_hold} !== 3'b100 || wr_addr.size() !== 0) begin
      n_bad++; $display("FAIL empty_frame: done=%b err=%b hold=%b writes=%0d required 1 0 0 0",
                        load_done, load_err, cpu_hold, wr_addr.size());
    end
  endtask

  task automatic test_oversize();
    pulse_reload();
    clear_log();
    send_frame('{8'hA5, 8'h04, 8'h01}, 0);
    @(negedge clk);
    n_cmp++;
    if ({load_err, load_done, cpu_hold, in_ready} !== 4'b1010 || wr_addr.size() !== 0) begin
      n_bad++; $display("FAIL oversize: err=%b done=%b hold=%b rdy=%b writes=%0d required 1 0 1 0 0",
                        load_err, load_done, cpu_hold, in_ready, wr_addr.size());
    end
  endtask

  task automatic test_reset_midframe();
    pulse_reload();
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, in_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL midreset_outputs: we=%b addr=%0d wdata=%h hold=%b done=%b err=%b rdy=%b",
                        im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h44332211) begin
      n_bad++; $display("FAIL midreset_writes: count=%0d required 1 (addr0=44332211)", wr_addr.size());
    end
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A}, 0);
    @(negedge clk);
    n_cmp++;
    if (load_done !== 1'b1 || wr_addr.size() !== 2 || wr_data[0] !== 32'h12345678 || wr_addr[1] !== 10'd1) begin
      n_bad++; $display("FAIL midreset_reload_frame: done=%b writes=%0d required 1 2", load_done, wr_addr.size());
    end
  endtask

  task automatic test_reload_one_word();
    pulse_reload();
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h01, 8'h0D, 8'hF0}, 0);
    @(negedge clk);
    n_cmp++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      n_bad++; $display("FAIL reload_hold_during_load: hold=%b done=%b required 1 0", cpu_hold, load_done);
    end
    send_frame('{8'hFE, 8'hCA, 8'hC9}, 0);
    @(negedge clk);
    n_cmp++;
    if ({load_done, cpu_hold} !== 2'b10 || wr_addr.size() !== 1) begin
      n_bad++; $display("FAIL reload_done: done=%b hold=%b writes=%0d required 1 0 1",
                        load_done, cpu_hold, wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hCAFEF00D) begin
        n_bad++; $display("FAIL reload_word: addr=%0d data=%h required 0 cafef00d", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_junk_empty();
    test_oversize();
    test_reset_midframe();
    test_reload_one_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
